// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 32-bit memory port between instruction fetch
// (IF) and load/store (LS) requesters. It grants one access at a time and
// waits a fixed memory latency. It then returns read data to the winner as a
// one-cycle registered rvalid pulse.
//
// Build option:
//   ARB_RR_EN  - when defined, contention is resolved round-robin: the
//                requester not granted last wins. A "last granted" register
//                resets to LS, so the first contest after reset goes to IF.
//                When undefined, LS always beats IF.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        addr_sel,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

    state_t     state;
    logic [2:0] cnt;
    logic       owner;
    logic       is_store;
    logic       grant_any;
    logic       ls_wins;

`ifdef ARB_RR_EN
    logic       last_ls;
`endif

    // Decide whether a grant issues this cycle and which requester wins it
    always_comb begin
        grant_any = (state == IDLE) && !rst && (if_req || ls_req);
`ifdef ARB_RR_EN
        ls_wins   = ls_req && (!if_req || !last_ls);
`else
        ls_wins   = ls_req;
`endif
    end

    assign if_gnt    = grant_any && !ls_wins;
    assign ls_gnt    = grant_any && ls_wins;
    assign mem_en    = grant_any;
    assign mem_we    = ls_gnt && ls_we;
    assign addr_sel  = grant_any ? ls_wins : owner;
    assign mem_addr  = addr_sel ? ls_addr : if_addr;
    assign mem_wdata = addr_sel ? ls_wdata : 32'h0;
    assign busy      = (state == WAIT);

    // Access sequencer: latch the winner, count down latency, return data
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            owner     <= 1'b0;
            is_store  <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= 32'h0;
            ls_rdata  <= 32'h0;
`ifdef ARB_RR_EN
            last_ls   <= 1'b1;
`endif
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state    <= WAIT;
                        cnt      <= LAT_LOAD;
                        owner    <= ls_wins;
                        is_store <= ls_wins && ls_we;
`ifdef ARB_RR_EN
                        last_ls  <= ls_wins;
`endif
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= IDLE;
                        if (owner) begin
                            ls_rvalid <= 1'b1;
                            if (!is_store) begin
                                ls_rdata <= mem_rdata;
                            end
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
